e7udp_vio_client: RTL and testbench

Host-side initiator for the UDP virtual-I/O register protocol on the UPL bus. It turns single-entry register commands (set, get, info) into UPL request packets and parses the returned reply and interrupt packets into response and interrupt strobes. It sits between a local controller, such as a test sequencer or a soft CPU, and the UPL UDP stack, opposite a VIO responder on the far end.

---
 rtl/e7udp_vio_pkg.sv | 50 +++++
 rtl/e7udp_vio_rx_parse.sv | 93 +++++++++
 rtl/e7udp_vio_client.sv | 207 ++++++++++++++++++++
 tb/tb_e7udp_vio_client.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/e7udp_vio_pkg.sv
// e7udp_vio_pkg: constants shared by the VIO client and the VIO responder.
// Holds the payload mode codes, request lengths, request word indices, FSM
// state types and a helper that returns the request length for a mode.
package e7udp_vio_pkg;

    // Payload mode codes (payload bits [9:8])
    localparam logic [1:0] MODE_IN   = 2'd0;  // set
    localparam logic [1:0] MODE_OUT  = 2'd1;  // get
    localparam logic [1:0] MODE_INFO = 2'd2;  // info
    localparam logic [1:0] MODE_IRQ  = 2'd3;  // interrupt (illegal as a command)

    // UDP length field values
    localparam logic [15:0] LEN_SET = 16'd8;
    localparam logic [15:0] LEN_GET = 16'd4;

    // Request packet word indices
    localparam logic [2:0] W_DST_IP  = 3'd0;
    localparam logic [2:0] W_SRC_IP  = 3'd1;
    localparam logic [2:0] W_PORTS   = 3'd2;
    localparam logic [2:0] W_LEN     = 3'd3;
    localparam logic [2:0] W_PAYLOAD = 3'd4;
    localparam logic [2:0] W_DATA    = 3'd5;

    typedef enum logic [2:0] {
        T_IDLE = 3'd0,
        T_REQ  = 3'd1,
        T_HDR  = 3'd2,
        T_ADDR = 3'd3,
        T_DATA = 3'd4,
        T_WAIT = 3'd5
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE    = 3'd0,
        R_HDR     = 3'd1,
        R_PAYLOAD = 3'd2,
        R_DATA    = 3'd3,
        R_DROP    = 3'd4
    } rx_state_t;

    // Set carries an extra data word, so its length is larger
    function automatic logic [15:0] req_len(input logic [1:0] mode);
        if (mode == MODE_IN) begin
            req_len = LEN_SET;
        end else begin
            req_len = LEN_GET;
        end
    endfunction

endpackage

// File: rtl/e7udp_vio_rx_parse.sv
// e7udp_vio_rx_parse: receive FSM and payload dispatch for the VIO client.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   r_enable, r_data     UPL receive word strobe and word
//   reply_valid          data word of a get/info reply is on r_data (combinational)
//   reply_mode/addr      mode/addr of that reply (held from the payload word)
//   reply_data           the reply data word (r_data passthrough)
//   irq_valid, irq_flags registered interrupt strobe and flags
module e7udp_vio_rx_parse
    import e7udp_vio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        r_enable,
    input  logic [31:0] r_data,
    output logic        reply_valid,
    output logic [1:0]  reply_mode,
    output logic [7:0]  reply_addr,
    output logic [31:0] reply_data,
    output logic        irq_valid,
    output logic [7:0]  irq_flags
);

    rx_state_t  rx_state_r;
    logic [1:0] hdr_cnt_r;

    // The reply strobe is combinational so the client can register its
    // response in the same edge that samples the data word.
    assign reply_valid = (rx_state_r == R_DATA) && r_enable;
    assign reply_data  = r_data;

    // Receive FSM; any cycle with r_enable low ends the current packet
    always_ff @(posedge clk) begin
        if (rst) begin
            // A packet already in flight at reset release is discarded whole
            rx_state_r <= r_enable ? R_DROP : R_IDLE;
            hdr_cnt_r  <= 2'd0;
            reply_mode <= 2'd0;
            reply_addr <= 8'd0;
            irq_valid  <= 1'b0;
            irq_flags  <= 8'd0;
        end else begin
            irq_valid <= 1'b0;
            case (rx_state_r)
                R_IDLE: begin
                    // Word 0 is consumed in this cycle
                    if (r_enable) begin
                        hdr_cnt_r  <= 2'd1;
                        rx_state_r <= R_HDR;
                    end
                end
                R_HDR: begin
                    if (!r_enable) begin
                        rx_state_r <= R_IDLE;
                    end else if (hdr_cnt_r == 2'd3) begin
                        rx_state_r <= R_PAYLOAD;
                    end else begin
                        hdr_cnt_r <= hdr_cnt_r + 2'd1;
                    end
                end
                R_PAYLOAD: begin
                    if (!r_enable) begin
                        rx_state_r <= R_IDLE;
                    end else begin
                        case (r_data[9:8])
                            MODE_IRQ: begin
                                irq_valid  <= 1'b1;
                                irq_flags  <= r_data[7:0];
                                rx_state_r <= R_DROP;
                            end
                            MODE_OUT, MODE_INFO: begin
                                reply_mode <= r_data[9:8];
                                reply_addr <= r_data[7:0];
                                rx_state_r <= R_DATA;
                            end
                            default: rx_state_r <= R_DROP;
                        endcase
                    end
                end
                R_DATA: begin
                    rx_state_r <= r_enable ? R_DROP : R_IDLE;
                end
                R_DROP: begin
                    if (!r_enable) begin
                        rx_state_r <= R_IDLE;
                    end
                end
                default: rx_state_r <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/e7udp_vio_client.sv
// e7udp_vio_client: host-side initiator for the UDP virtual-I/O protocol.
// Turns set/get/info commands into UPL request packets and turns reply and
// interrupt packets into rsp_* and irq_* strobes.
// Ports: cmd_* command handshake, rsp_* response strobe, irq_* interrupt
// strobe, r_* UPL receive side, w_* UPL transmit side.
// Optional: define E7UDP_VIO_CLIENT_TIMEOUT_EN to bound the reply wait by
// TIMEOUT_CYCLES; otherwise a get/info waits indefinitely.
module e7udp_vio_client
    import e7udp_vio_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP       = 32'h0A000001,
    parameter logic [31:0] REMOTE_IP      = 32'h0A000002,
    parameter logic [15:0] LOCAL_PORT     = 16'd16384,
    parameter logic [15:0] REMOTE_PORT    = 16'd16385,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_mode,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [1:0]  rsp_mode,
    output logic [7:0]  rsp_addr,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        irq_valid,
    output logic [7:0]  irq_flags,
    input  logic        r_req,
    input  logic        r_enable,
    output logic        r_ack,
    input  logic [31:0] r_data,
    output logic        w_req,
    output logic        w_enable,
    input  logic        w_ack,
    output logic [31:0] w_data
);

    tx_state_t   tx_state_r;
    logic [1:0]  cmd_mode_r;
    logic [7:0]  cmd_addr_r;
    logic [31:0] cmd_wdata_r;
    logic [2:0]  wcnt_r;
    logic        reply_valid_s;
    logic [1:0]  reply_mode_s;
    logic [7:0]  reply_addr_s;
    logic [31:0] reply_data_s;
    logic        unused_r_req_s;
`ifdef E7UDP_VIO_CLIENT_TIMEOUT_EN
    logic [31:0] tmo_cnt_r;
`else
    logic [31:0] unused_tmo_s;
    assign unused_tmo_s = 32'(TIMEOUT_CYCLES);
`endif

    // Receive words are qualified by r_enable alone
    assign unused_r_req_s = r_req;
    assign r_ack = 1'b1;

    // Request word for a given index of the latched command
    function automatic logic [31:0] tx_word(input logic [2:0] idx,
                                            input logic [1:0] mode,
                                            input logic [7:0] addr,
                                            input logic [31:0] wdata);
        case (idx)
            W_DST_IP:  tx_word = REMOTE_IP;
            W_SRC_IP:  tx_word = LOCAL_IP;
            W_PORTS:   tx_word = {REMOTE_PORT, LOCAL_PORT};
            W_LEN:     tx_word = {16'h0000, req_len(mode)};
            W_PAYLOAD: tx_word = {22'h000000, mode, addr};
            W_DATA:    tx_word = wdata;
            default:   tx_word = 32'h00000000;
        endcase
    endfunction

    e7udp_vio_rx_parse u_rx (
        .clk         (clk),
        .rst         (rst),
        .r_enable    (r_enable),
        .r_data      (r_data),
        .reply_valid (reply_valid_s),
        .reply_mode  (reply_mode_s),
        .reply_addr  (reply_addr_s),
        .reply_data  (reply_data_s),
        .irq_valid   (irq_valid),
        .irq_flags   (irq_flags)
    );

    // Transmit FSM, command latch, reply matching and response strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r  <= T_IDLE;
            cmd_ready   <= 1'b0;
            cmd_mode_r  <= 2'd0;
            cmd_addr_r  <= 8'd0;
            cmd_wdata_r <= 32'd0;
            wcnt_r      <= 3'd0;
            w_req       <= 1'b0;
            w_enable    <= 1'b0;
            w_data      <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_mode    <= 2'd0;
            rsp_addr    <= 8'd0;
            rsp_data    <= 32'd0;
            rsp_timeout <= 1'b0;
`ifdef E7UDP_VIO_CLIENT_TIMEOUT_EN
            tmo_cnt_r   <= 32'd0;
`endif
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (tx_state_r)
                T_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_mode_r  <= cmd_mode;
                        cmd_addr_r  <= cmd_addr;
                        cmd_wdata_r <= cmd_wdata;
                        if (cmd_mode == MODE_IRQ) begin
                            // Illegal mode: answer at once, send nothing,
                            // and stay ready for the next command
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_mode    <= cmd_mode;
                            rsp_addr    <= cmd_addr;
                            rsp_data    <= 32'd0;
                        end else begin
                            cmd_ready  <= 1'b0;
                            w_req      <= 1'b1;
                            tx_state_r <= T_REQ;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                T_REQ: begin
                    if (w_ack) begin
                        w_req      <= 1'b0;
                        w_enable   <= 1'b1;
                        w_data     <= tx_word(W_DST_IP, cmd_mode_r, cmd_addr_r, cmd_wdata_r);
                        wcnt_r     <= 3'd1;
                        tx_state_r <= T_HDR;
                    end
                end
                T_HDR: begin
                    // State names the word currently on the bus: header
                    // words 0..3 here, the payload word in T_ADDR
                    w_data <= tx_word(wcnt_r, cmd_mode_r, cmd_addr_r, cmd_wdata_r);
                    wcnt_r <= wcnt_r + 3'd1;
                    if (wcnt_r == W_PAYLOAD) begin
                        tx_state_r <= T_ADDR;
                    end
                end
                T_ADDR: begin
                    if (cmd_mode_r == MODE_IN) begin
                        w_data     <= cmd_wdata_r;
                        tx_state_r <= T_DATA;
                    end else begin
                        w_enable   <= 1'b0;
                        w_data     <= 32'd0;
                        tx_state_r <= T_WAIT;
`ifdef E7UDP_VIO_CLIENT_TIMEOUT_EN
                        tmo_cnt_r  <= 32'd0;
`endif
                    end
                end
                T_DATA: begin
                    w_enable   <= 1'b0;
                    w_data     <= 32'd0;
                    rsp_valid  <= 1'b1;
                    rsp_mode   <= cmd_mode_r;
                    rsp_addr   <= cmd_addr_r;
                    rsp_data   <= 32'd0;
                    cmd_ready  <= 1'b1;
                    tx_state_r <= T_IDLE;
                end
                T_WAIT: begin
                    if (reply_valid_s && (reply_mode_s == cmd_mode_r) &&
                        (reply_addr_s == cmd_addr_r)) begin
                        rsp_valid  <= 1'b1;
                        rsp_mode   <= cmd_mode_r;
                        rsp_addr   <= cmd_addr_r;
                        rsp_data   <= reply_data_s;
                        cmd_ready  <= 1'b1;
                        tx_state_r <= T_IDLE;
`ifdef E7UDP_VIO_CLIENT_TIMEOUT_EN
                    end else if (tmo_cnt_r == 32'(TIMEOUT_CYCLES - 1)) begin
                        // Strobe lands TIMEOUT_CYCLES cycles after T_WAIT entry
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_mode    <= cmd_mode_r;
                        rsp_addr    <= cmd_addr_r;
                        rsp_data    <= 32'd0;
                        cmd_ready   <= 1'b1;
                        tx_state_r  <= T_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 32'd1;
`endif
                    end
                end
                default: tx_state_r <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e7udp_vio_client.sv
// Scoreboard bench for e7udp_vio_client: stimulus pushes expected transmit
// words, responses and interrupts; a negedge monitor pops and compares.
module tb_e7udp_vio_client;

    localparam logic [31:0] L_IP   = 32'h0A000001;
    localparam logic [31:0] R_IP   = 32'h0A000002;
    localparam logic [15:0] L_PORT = 16'd16384;
    localparam logic [15:0] R_PORT = 16'd16385;
    localparam int          TB_TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_mode = 2'd0;
    logic [7:0] cmd_addr = 8'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic rsp_valid, rsp_timeout, irq_valid, r_ack, w_req, w_enable;
    logic [1:0] rsp_mode;
    logic [7:0] rsp_addr, irq_flags;
    logic [31:0] rsp_data, w_data;
    logic r_req = 1'b0, r_enable = 1'b0, w_ack = 1'b1;
    logic [31:0] r_data = 32'd0;
    logic ack_rand = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tx_q[$];
    logic [42:0] rsp_q[$];   // {mode, addr, data, timeout}
    logic [7:0]  irq_q[$];

    e7udp_vio_client #(
        .LOCAL_IP(L_IP), .REMOTE_IP(R_IP), .LOCAL_PORT(L_PORT),
        .REMOTE_PORT(R_PORT), .TIMEOUT_CYCLES(TB_TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_mode(rsp_mode), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .irq_valid(irq_valid), .irq_flags(irq_flags),
        .r_req(r_req), .r_enable(r_enable), .r_ack(r_ack), .r_data(r_data),
        .w_req(w_req), .w_enable(w_enable), .w_ack(w_ack), .w_data(w_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant driver: random back-pressure on w_ack when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            w_ack = ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: every observed strobe must match the head of its queue
    always @(negedge clk) begin
        logic [42:0] e;
        if (!rst) begin
            if (w_enable) begin
                if (tx_q.size() == 0) check("tx_unexpected", {32'd0, w_data}, 64'hFFFFFFFFFFFFFFFF);
                else check("tx_word", {32'd0, w_data}, {32'd0, tx_q.pop_front()});
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
                else begin
                    e = rsp_q.pop_front();
                    check("rsp", {21'd0, rsp_mode, rsp_addr, rsp_data, rsp_timeout}, {21'd0, e});
                end
            end
            if (irq_valid) begin
                if (irq_q.size() == 0) check("irq_unexpected", {56'd0, irq_flags}, 64'hFFFF);
                else check("irq_flags", {56'd0, irq_flags}, {56'd0, irq_q.pop_front()});
            end
        end
    end

    // Model: request packet words and the response a command must produce
    task automatic issue(input logic [1:0] mode, input logic [7:0] addr, input logic [31:0] wdata);
        int i;
        for (i = 0; i < 300 && !cmd_ready; i++) tick();
        if (!cmd_ready) begin
            check("cmd_ready_wait", 64'd0, 64'd1);
            return;
        end
        if (mode == 2'd3) begin
            rsp_q.push_back({mode, addr, 32'd0, 1'b1});
        end else begin
            tx_q.push_back(R_IP);
            tx_q.push_back(L_IP);
            tx_q.push_back({R_PORT, L_PORT});
            tx_q.push_back((mode == 2'd0) ? 32'd8 : 32'd4);
            tx_q.push_back({22'd0, mode, addr});
            if (mode == 2'd0) begin
                tx_q.push_back(wdata);
                rsp_q.push_back({mode, addr, 32'd0, 1'b0});
            end
        end
        cmd_valid = 1'b1; cmd_mode = mode; cmd_addr = addr; cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait until all request words are out and the client is waiting
    task automatic wait_tx_done();
        int i;
        for (i = 0; i < 300; i++) begin
            if (tx_q.size() == 0 && !w_enable) return;
            tick();
        end
        check("tx_done_wait", 64'd0, 64'd1);
    endtask

    // Drive a receive packet of nwords words; payload is word 4, data word 5
    task automatic send_pkt(input logic [31:0] payload, input logic [31:0] data, input int nwords);
        if (payload[9:8] == 2'd3 && nwords >= 5) irq_q.push_back(payload[7:0]);
        for (int i = 0; i < nwords; i++) begin
            r_enable = 1'b1; r_req = 1'b1;
            r_data = (i == 4) ? payload : (i == 5) ? data : $urandom;
            tick();
        end
        r_enable = 1'b0; r_req = 1'b0; r_data = 32'd0;
        tick();
    endtask

    // Get/info with an optional non-completing packet before the reply
    task automatic do_get(input logic [1:0] mode, input logic [7:0] addr,
                          input logic [31:0] data, input int extra);
        logic [7:0] flags;
        issue(mode, addr, 32'd0);
        wait_tx_done();
        flags = 8'($urandom);
        case (extra)
            1: send_pkt({22'd0, mode, addr ^ 8'($urandom_range(1, 255))}, $urandom, 6);
            2: send_pkt({22'd0, mode ^ 2'b11, addr}, $urandom, 6);
            3: send_pkt({22'd0, 2'd3, flags}, $urandom, $urandom_range(5, 6));
            4: send_pkt({22'd0, mode, addr}, $urandom, 5);
            5: send_pkt({22'd0, 2'd0, addr}, $urandom, 6);
            default: ;
        endcase
        rsp_q.push_back({mode, addr, data, 1'b0});
        send_pkt({22'd0, mode, addr}, data, 6);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_w_req", {63'd0, w_req}, 64'd0);
        check("rst_w_enable", {63'd0, w_enable}, 64'd0);
        check("rst_w_data", {32'd0, w_data}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_irq_valid", {63'd0, irq_valid}, 64'd0);
        check("r_ack", {63'd0, r_ack}, 64'd1);
        rst = 1'b0;
        tick();
        check("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        // Set, then get, mismatch, irq during wait, illegal mode
        issue(2'd0, 8'd3, 32'hDEADBEEF);
        wait_tx_done();
        repeat (2) tick();
        do_get(2'd1, 8'd1, 32'h12345678, 0);
        issue(2'd1, 8'd1, 32'd0);
        wait_tx_done();
        send_pkt(32'h00000102, 32'hBAD0BAD0, 6);
        rsp_q.push_back({2'd1, 8'd1, 32'hCAFEF00D, 1'b0});
        send_pkt(32'h00000101, 32'hCAFEF00D, 6);
        issue(2'd1, 8'd1, 32'd0);
        wait_tx_done();
        send_pkt(32'h00000305, 32'd0, 5);
        rsp_q.push_back({2'd1, 8'd1, 32'h55AA1234, 1'b0});
        send_pkt(32'h00000101, 32'h55AA1234, 6);
        issue(2'd3, 8'h42, 32'd0);
        tick();
        // Reply while idle is dropped
        send_pkt(32'h00000101, 32'h11111111, 6);

`ifdef E7UDP_VIO_CLIENT_TIMEOUT_EN
        issue(2'd2, 8'd7, 32'd0);
        wait_tx_done();
        rsp_q.push_back({2'd2, 8'd7, 32'd0, 1'b1});
        n = 0;
        while (n < 40 && !rsp_valid) begin
            tick();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(TB_TMO));
        repeat (2) tick();
        send_pkt(32'h00000207, 32'h77777777, 6);
`endif

        // Reset during tx word 2 and mid-rx packet
        issue(2'd0, 8'd9, 32'h0BADF00D);
        for (n = 0; n < 50 && !w_enable; n++) tick();
        r_enable = 1'b1; r_req = 1'b1; r_data = $urandom; tick();
        r_data = $urandom; tick();
        r_data = $urandom; rst = 1'b1;
        tx_q.delete(); rsp_q.delete();
        tick();
        rst = 1'b0;
        check("rst_mid_w_enable", {63'd0, w_enable}, 64'd0);
        check("rst_mid_w_req", {63'd0, w_req}, 64'd0);
        check("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        r_data = $urandom; tick();
        r_data = 32'h000003AA; tick();
        r_data = $urandom; tick();
        r_enable = 1'b0; r_req = 1'b0; r_data = 32'd0;
        repeat (3) tick();

        // Randomized traffic
        ack_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: issue(2'd0, 8'($urandom), $urandom);
                3, 4, 5, 6: do_get(2'($urandom_range(1, 2)), 8'($urandom), $urandom,
                                   $urandom_range(0, 5));
                7: issue(2'd3, 8'($urandom), $urandom);
                8: begin
                    wait_tx_done();
                    send_pkt({22'd0, 2'($urandom_range(0, 2)), 8'($urandom)}, $urandom, 6);
                end
                default: send_pkt({22'd0, 2'd3, 8'($urandom)}, $urandom, $urandom_range(5, 7));
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end
        ack_rand = 1'b0;

        // Drain and confirm nothing expected is left unseen
        for (n = 0; n < 200; n++) begin
            if (tx_q.size() == 0 && rsp_q.size() == 0 && irq_q.size() == 0) break;
            tick();
        end
        repeat (5) tick();
        check("tx_q_empty", 64'(tx_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        check("irq_q_empty", 64'(irq_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

endmodule
